// File: rtl/nrisc_pkg.sv
// Shared nRisc definitions: machine widths, reset PC, halt opcode and the
// address/instruction types used by fetch, decode and program memory.
package nrisc_pkg;

  localparam int ADDR_W  = 8;
  localparam int INSTR_W = 8;

  typedef logic [ADDR_W-1:0]  addr_t;
  typedef logic [INSTR_W-1:0] instr_t;

  localparam addr_t  RESET_PC    = 8'h00;
  localparam instr_t HALT_OPCODE = 8'hFF;

endpackage

// File: rtl/pc_next.sv
// Next-PC selection for the fetch stage: absolute jump, instr_pc-relative
// branch, sequential increment or hold. All arithmetic wraps modulo 2^ADDR_W.
module pc_next #(
  parameter int ADDR_W = nrisc_pkg::ADDR_W
) (
  input  logic [ADDR_W-1:0] pc,
  input  logic [ADDR_W-1:0] instr_pc,
  input  logic              jump_en,
  input  logic [ADDR_W-1:0] jump_target,
  input  logic              branch_en,
  input  logic [ADDR_W-1:0] branch_offset,
  input  logic              fetch,
  output logic [ADDR_W-1:0] next_pc,
  output logic              redirect
);

  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    next_pc  = pc;
    redirect = jump_en | branch_en;
    if (jump_en) begin
      next_pc = jump_target;
    end else if (branch_en) begin
      // Offset is two's complement; a same-width add wraps exactly as required.
      next_pc = instr_pc + branch_offset;
    end else if (fetch) begin
      next_pc = pc + ADDR_W'(1);
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// nRisc instruction fetch: PC register, instruction register with valid/ready
// hand-off to decode, jump/branch redirect with one-bubble flush, halt on HALT_OPCODE.
module fetch_unit #(
  parameter int                   ADDR_W      = nrisc_pkg::ADDR_W,
  parameter int                   INSTR_W     = nrisc_pkg::INSTR_W,
  parameter logic [ADDR_W-1:0]    RESET_PC    = nrisc_pkg::RESET_PC,
  parameter logic [INSTR_W-1:0]   HALT_OPCODE = nrisc_pkg::HALT_OPCODE
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic [ADDR_W-1:0]  pc,
  input  logic [INSTR_W-1:0] memory_instruction,
  output logic [INSTR_W-1:0] instr_out,
  output logic [ADDR_W-1:0]  instr_pc,
  output logic               instr_valid,
  input  logic               instr_ready,
  input  logic               jump_en,
  input  logic [ADDR_W-1:0]  jump_target,
  input  logic               branch_en,
  input  logic [ADDR_W-1:0]  branch_offset,
  output logic               halted
);

  logic              fetch;
  logic              drain;
  logic              redirect;
  logic [ADDR_W-1:0] next_pc;

  // Fetch whenever not halted and the instruction register is empty or being consumed.
  assign fetch = !halted && (!instr_valid || instr_ready);
  assign drain = halted && instr_valid && instr_ready;

  pc_next #(.ADDR_W(ADDR_W)) u_pc_next (
    .pc            (pc),
    .instr_pc      (instr_pc),
    .jump_en       (jump_en),
    .jump_target   (jump_target),
    .branch_en     (branch_en),
    .branch_offset (branch_offset),
    .fetch         (fetch),
    .next_pc       (next_pc),
    .redirect      (redirect)
  );

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc          <= RESET_PC;
      instr_out   <= '0;
      instr_pc    <= '0;
      instr_valid <= 1'b0;
      halted      <= 1'b0;
    end else if (redirect) begin
      // Flush: the in-flight instruction is discarded and instr_ready is ignored.
      pc          <= next_pc;
      instr_valid <= 1'b0;
      halted      <= 1'b0;
    end else if (fetch) begin
      pc          <= next_pc;
      instr_out   <= memory_instruction;
      instr_pc    <= pc;
      instr_valid <= 1'b1;
      halted      <= (memory_instruction == HALT_OPCODE);
    end else if (drain) begin
      instr_valid <= 1'b0;
    end
  end

endmodule
